// File: rtl/result_collector.sv
// Result collector: captures controller result bursts into a FIFO and serves them
// to the MCU through a pulse-request/ack read port, with status, done and sticky error flags.
module result_collector #(
    parameter int DATA_W = 16,
    parameter int BUS_W  = 32,
    parameter int DEPTH  = 64,
    parameter bit SIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              read,
    input  logic [DATA_W-1:0] res_data,
    input  logic [7:0]        column_size,
    input  logic              clr,
    input  logic              rd_req,
    output logic [BUS_W-1:0]  rd_data,
    output logic              rd_ack,
    output logic [31:0]       status,
    output logic              irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state_q;
    logic              read_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [7:0]        captured_q;
    logic              ovf_q;
    logic              udf_q;
    logic              discard_q;
    logic              done_q;
    logic [BUS_W-1:0]  rd_data_q;
    logic              rd_ack_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              start_s;
    logic              pop_s;
    logic              full_s;
    logic              push_s;
    logic              drop_s;
    logic [AW-1:0]     wr_addr_s;

    function automatic logic [BUS_W-1:0] extend(input logic [DATA_W-1:0] w);
        if (SIGNED) begin
            extend = BUS_W'($signed(w));
        end else begin
            extend = BUS_W'(w);
        end
    endfunction

    // Push/pop decode; a burst start flushes first, so full is judged on the empty FIFO
    always_comb begin
        start_s   = read && !read_q;
        pop_s     = rd_req && (count_q != CW'(0));
        full_s    = start_s ? 1'b0 : (count_q == CW'(DEPTH));
        push_s    = read && (!full_s || pop_s);
        drop_s    = read && full_s && !pop_s;
        wr_addr_s = start_s ? AW'(0) : wr_ptr_q;
        if (clr) begin
            count_d = CW'(0);
        end else if (start_s) begin
            count_d = CW'(1);
        end else begin
            count_d = count_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // FIFO storage, written at the flush-adjusted write address
    always_ff @(posedge clk) begin
        if (push_s && !clr) begin
            mem_q[wr_addr_s] <= res_data;
        end
    end

    // Control FSM, pointers, counters, flags and the registered read port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            read_q     <= 1'b0;
            wr_ptr_q   <= AW'(0);
            rd_ptr_q   <= AW'(0);
            count_q    <= CW'(0);
            captured_q <= 8'd0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            discard_q  <= 1'b0;
            done_q     <= 1'b0;
            rd_data_q  <= BUS_W'(0);
            rd_ack_q   <= 1'b0;
        end else begin
            read_q   <= read;
            rd_ack_q <= rd_req;
            count_q  <= count_d;
            if (clr) begin
                state_q    <= IDLE;
                wr_ptr_q   <= AW'(0);
                rd_ptr_q   <= AW'(0);
                captured_q <= 8'd0;
                ovf_q      <= 1'b0;
                udf_q      <= 1'b0;
                discard_q  <= 1'b0;
                done_q     <= 1'b0;
                if (rd_req) begin
                    rd_data_q <= BUS_W'(0);
                end
            end else begin
                if (rd_req) begin
                    rd_data_q <= pop_s ? extend(mem_q[rd_ptr_q]) : BUS_W'(0);
                    if (!pop_s) begin
                        udf_q <= 1'b1;
                    end
                end
                if (drop_s) begin
                    ovf_q <= 1'b1;
                end
                if (start_s) begin
                    wr_ptr_q   <= AW'(1);
                    rd_ptr_q   <= AW'(0);
                    captured_q <= 8'd1;
                    done_q     <= 1'b0;
                    state_q    <= CAPTURE;
                    if (count_q != CW'(0)) begin
                        discard_q <= 1'b1;
                    end
                end else begin
                    wr_ptr_q <= wr_ptr_q + AW'(push_s);
                    rd_ptr_q <= rd_ptr_q + AW'(pop_s);
                    if (read && (captured_q != 8'd255)) begin
                        captured_q <= captured_q + 8'd1;
                    end
                    case (state_q)
                        CAPTURE: begin
                            if (!read) begin
                                state_q <= DONE;
                                done_q  <= (captured_q == column_size);
                            end
                        end
                        DONE: begin
                            if (pop_s && (count_d == CW'(0))) begin
                                state_q <= IDLE;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign rd_data = rd_data_q;
    assign rd_ack  = rd_ack_q;
    assign status  = {16'h0000, ovf_q, udf_q, discard_q, done_q, 4'h0, 8'(count_q)};
    assign irq     = (state_q == DONE) && (count_q != CW'(0));

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: a queue-based reference model predicts every
// ack word and the status/irq view; a negedge monitor compares whatever the DUT presents.
module tb_result_collector;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        read = 1'b0;
    logic [15:0] res_data = 16'h0000;
    logic [7:0]  column_size = 8'd0;
    logic        clr = 1'b0;
    logic        rd_req = 1'b0;
    logic [31:0] rd_data;
    logic        rd_ack;
    logic [31:0] status;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_q[$];
    logic [31:0] exp_q[$];
    int          m_captured;
    bit          m_ovf, m_udf, m_disc, m_done, m_prev_read, m_ack;
    int          m_state;            // 0 idle, 1 capturing, 2 burst finished
    logic [31:0] m_last = 32'h0;

    result_collector #(.DATA_W(16), .BUS_W(32), .DEPTH(DEPTH), .SIGNED(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .read(read), .res_data(res_data),
        .column_size(column_size), .clr(clr), .rd_req(rd_req),
        .rd_data(rd_data), .rd_ack(rd_ack), .status(status), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sext(input logic [15:0] w);
        int v;
        v = $signed(w);
        return 32'(v);
    endfunction

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_captured  = 0;
        m_ovf       = 1'b0;
        m_udf       = 1'b0;
        m_disc      = 1'b0;
        m_done      = 1'b0;
        m_prev_read = 1'b0;
        m_ack       = 1'b0;
        m_state     = 0;
    endtask

    task automatic model_step(input bit r, input logic [15:0] d, input bit q, input bit c);
        int  n0;
        bit  start;
        bit  popped;
        m_ack  = q;
        popped = 1'b0;
        if (c) begin
            m_q.delete();
            m_captured = 0;
            m_ovf = 1'b0; m_udf = 1'b0; m_disc = 1'b0; m_done = 1'b0;
            m_state = 0;
            if (q) exp_q.push_back(32'h0);
        end else begin
            n0    = m_q.size();
            start = r && !m_prev_read;
            if (q) begin
                if (n0 != 0) begin
                    exp_q.push_back(sext(m_q.pop_front()));
                    popped = 1'b1;
                end else begin
                    exp_q.push_back(32'h0);
                    m_udf = 1'b1;
                end
            end
            if (start) begin
                if (n0 != 0) m_disc = 1'b1;
                m_q.delete();
                m_captured = 0;
                m_done = 1'b0;
            end
            if (r) begin
                if (m_captured < 255) m_captured++;
                if (m_q.size() < DEPTH) m_q.push_back(d);
                else m_ovf = 1'b1;
            end
            if (start) begin
                m_state = 1;
            end else if (m_state == 1 && !r) begin
                m_state = 2;
                m_done  = (m_captured == int'(column_size));
            end else if (m_state == 2 && popped && m_q.size() == 0) begin
                m_state = 0;
            end
        end
        m_prev_read = r;
    endtask

    task automatic cyc(input bit r, input logic [15:0] d, input bit q, input bit c);
        read = r; res_data = d; rd_req = q; clr = c;
        @(posedge clk);
        model_step(r, d, q, c);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b0);
            cyc(1'b0, 16'h0, 1'b0, 1'b0);
        end
    endtask

    // Monitor: pops the scoreboard on each ack and checks the status view every cycle
    always @(negedge clk) begin
        if (!reset_n) m_last = 32'h0;
        check("rd_ack", {31'h0, rd_ack}, {31'h0, m_ack});
        if (rd_ack) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rd_data: ack with no pending request, got %h", rd_data);
            end else begin
                m_last = exp_q.pop_front();
            end
        end
        check("rd_data", rd_data, m_last);
        check("status", status, {16'h0, m_ovf, m_udf, m_disc, m_done, 4'h0, 8'(m_q.size())});
        check("irq", {31'h0, irq}, {31'h0, (m_state == 2 && m_q.size() != 0)});
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        idle(2);

        // T1: 4-word burst including a negative value, then four reads
        column_size = 8'd4;
        cyc(1'b1, 16'h0001, 1'b0, 1'b0);
        cyc(1'b1, 16'h0002, 1'b0, 1'b0);
        cyc(1'b1, 16'h0003, 1'b0, 1'b0);
        cyc(1'b1, 16'hFFFF, 1'b0, 1'b0);
        idle(2);
        check("t1_done", {31'h0, status[12]}, 32'h1);
        drain(4);
        check("t1_irq_low", {31'h0, irq}, 32'h0);

        // T3: read of an empty FIFO
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        drain(1);
        check("t3_udf", {31'h0, status[14]}, 32'h1);

        // T2: 66-word burst overflows a 64-entry FIFO
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        column_size = 8'd66;
        for (int i = 0; i < 66; i++) cyc(1'b1, 16'(i + 100), 1'b0, 1'b0);
        idle(1);
        check("t2_count", {24'h0, status[7:0]}, 32'd64);
        check("t2_ovf", {31'h0, status[15]}, 32'h1);
        drain(64);

        // T4: full FIFO, push and pop in the same cycle
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 64; i++) cyc(1'b1, 16'(i + 16'h0200), 1'b0, 1'b0);
        cyc(1'b1, 16'h7777, 1'b1, 1'b0);
        idle(1);
        check("t4_count", {24'h0, status[7:0]}, 32'd64);
        check("t4_ovf", {31'h0, status[15]}, 32'h0);
        drain(64);

        // T5: unread words discarded by a new burst, for matching and mismatching sizes
        for (int k = 2; k <= 3; k++) begin
            cyc(1'b0, 16'h0, 1'b0, 1'b1);
            column_size = 8'd2;
            if (k == 3) column_size = 8'd3;
            for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'h0A00 + i), 1'b0, 1'b0);
            idle(2);
            for (int i = 0; i < 2; i++) cyc(1'b1, 16'(16'h0B00 + i), 1'b0, 1'b0);
            idle(1);
            check("t5_discard", {31'h0, status[13]}, 32'h1);
            check("t5_done", {31'h0, status[12]}, (k == 2) ? 32'h1 : 32'h0);
            drain(2);
        end

        // Randomized bursts, reads and clears
        for (int it = 0; it < 250; it++) begin
            int len;
            len = $urandom_range(0, 12);
            column_size = 8'($urandom_range(0, 12));
            for (int i = 0; i < len; i++)
                cyc(1'b1, 16'($urandom), ($urandom_range(0, 2) == 0), 1'b0);
            for (int g = 0; g < int'($urandom_range(1, 6)); g++) begin
                if ($urandom_range(0, 30) == 0) cyc(1'b0, 16'h0, 1'b0, 1'b1);
                else cyc(1'b0, 16'h0, ($urandom_range(0, 1) == 0), 1'b0);
            end
        end
        drain(DEPTH + 2);

        // T6: asynchronous reset in the middle of a burst
        column_size = 8'd3;
        cyc(1'b1, 16'h1111, 1'b0, 1'b0);
        cyc(1'b1, 16'h2222, 1'b1, 1'b0);
        read = 1'b0; rd_req = 1'b0;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("t6_rd_data", rd_data, 32'h0);
        check("t6_rd_ack", {31'h0, rd_ack}, 32'h0);
        check("t6_status", status, 32'h0);
        check("t6_irq", {31'h0, irq}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(1);
        cyc(1'b1, 16'h8001, 1'b0, 1'b0);
        cyc(1'b1, 16'h0042, 1'b0, 1'b0);
        cyc(1'b1, 16'h0043, 1'b0, 1'b0);
        idle(1);
        check("t6_done", {31'h0, status[12]}, 32'h1);
        drain(3);
        idle(2);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
